// File: rtl/avalon_pio_gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO bank: register offsets, edge encodings, bus width.
package avalon_pio_gpio_pkg;

   localparam int BUS_W = 32;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/avalon_pio_gpio_if.sv
// Avalon-MM slave bus for one GPIO bank: word address, select, active-low write, 32-bit data.
interface avalon_pio_gpio_if;
   import avalon_pio_gpio_pkg::*;

   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [BUS_W-1:0] writedata;
   logic [BUS_W-1:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_gpio_sync_edge.sv
// Input synchroniser plus one history flop; edge_pulse is valid SYNC_STAGES clocks after in_port moves.
// Purely streaming, no backpressure: one pulse per detected edge per clock.
module pio_sync_edge
   import avalon_pio_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: edge_pulse = ~sync_in & prev;
         EDGE_ANY:     edge_pulse = sync_in ^ prev;
         default:      edge_pulse = sync_in & ~prev;
      endcase
   end

endmodule

// File: rtl/avalon_pio_gpio.sv
// Parametrised Avalon-MM GPIO: output register with set/clear, captured inputs, maskable level irq.
// Read latency 1, writes land at the clock edge; slave is always ready (no waitrequest).
module avalon_pio_gpio
   import avalon_pio_gpio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_TYPE   = EDGE_RISING
) (
   input  logic               clk,
   input  logic               reset,
   avalon_pio_gpio_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic               irq
);

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_pulse;
   logic [BUS_W-1:0] readdata_q;
   logic [BUS_W-1:0] rd_mux;
   logic [WIDTH-1:0] wdat;
   logic             wr;
   logic             rd;
   logic             unused_wdat;

   pio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset      (reset),
      .in_port    (in_port),
      .sync_in    (sync_in),
      .edge_pulse (edge_pulse)
   );

   assign wr          = bus.chipselect & ~bus.write_n;
   assign rd          = bus.chipselect &  bus.write_n;
   assign wdat        = bus.writedata[WIDTH-1:0];
   assign unused_wdat = ^bus.writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= RESET_VALUE[WIDTH-1:0];
         irq_mask <= '0;
      end else if (wr) begin
         case (bus.address)
            ADDR_DATA:     data_out <= wdat;
            ADDR_OUTSET:   data_out <= data_out | wdat;
            ADDR_OUTCLR:   data_out <= data_out & ~wdat;
            ADDR_IRQ_MASK: irq_mask <= wdat;
            default:       ;
         endcase
      end
   end

   // Clear is applied before the OR so a coincident edge always leaves the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_capture <= '0;
      end else if (wr && bus.address == ADDR_EDGE_CAP) begin
         edge_capture <= (edge_capture & ~wdat) | edge_pulse;
      end else begin
         edge_capture <= edge_capture | edge_pulse;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA:     rd_mux[WIDTH-1:0] = data_out;
         ADDR_DATA_IN:  rd_mux[WIDTH-1:0] = sync_in;
         ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_capture;
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   readdata_q <= '0;
      else if (rd) readdata_q <= rd_mux;
   end

   assign bus.readdata = readdata_q;
   assign out_port     = data_out;
   assign irq          = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Bench for two GPIO banks (8-bit rising-edge, 32-bit any-edge) sharing one clock and reset.
module tb_avalon_pio_gpio;
   import avalon_pio_gpio_pkg::*;

   localparam logic [31:0] RV_A = 32'h0000_005A;
   localparam logic [31:0] RV_B = 32'hA5A5_0001;

   logic        clk;
   logic        reset;
   logic [7:0]  in_a;
   logic [7:0]  out_a;
   logic        irq_a;
   logic [31:0] in_b;
   logic [31:0] out_b;
   logic        irq_b;

   avalon_pio_gpio_if bus_a ();
   avalon_pio_gpio_if bus_b ();

   avalon_pio_gpio #(.WIDTH(8), .RESET_VALUE(RV_A), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_a), .out_port(out_a), .irq(irq_a));

   avalon_pio_gpio #(.WIDTH(32), .RESET_VALUE(RV_B), .SYNC_STAGES(3), .EDGE_TYPE(EDGE_ANY)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .in_port(in_b), .out_port(out_b), .irq(irq_b));

   typedef struct {
      string       tag;
      logic [31:0] exp;
      bit          sel;
   } sb_item_t;

   sb_item_t sb_q[$];
   int n_total = 0;
   int n_bad   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_idle();
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
      bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
   endtask

   // Entered and left on a falling edge; the write lands on the rising edge in between.
   task automatic bus_wr(input bit sel, input logic [2:0] addr, input logic [31:0] d);
      if (!sel) begin
         bus_a.address = addr; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
      end else begin
         bus_b.address = addr; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
      end
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_rd(input bit sel, input logic [2:0] addr, input logic [31:0] exp, input string tag);
      sb_item_t it;
      logic [31:0] got;
      if (!sel) begin
         bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
      end else begin
         bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
      end
      sb_q.push_back('{tag, exp, sel});
      @(negedge clk);
      bus_idle();
      if (sb_q.size() == 0) begin
         n_total++; n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         it  = sb_q.pop_front();
         got = it.sel ? bus_b.readdata : bus_a.readdata;
         chk(it.tag, got, it.exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      in_a  = '0;
      in_b  = '0;
      bus_a.address = '0; bus_a.writedata = '0;
      bus_b.address = '0; bus_b.writedata = '0;
      bus_idle();
      tick(2);

      chk("rst_out_a", {24'h0, out_a}, RV_A);
      chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
      chk("rst_rd_a",  bus_a.readdata, 32'h0);
      chk("rst_out_b", out_b, RV_B);
      reset = 1'b0;
      tick(1);
      bus_rd(0, ADDR_DATA, 32'h0000_005A, "rd_reset_data");

      bus_wr(0, ADDR_DATA, 32'h0000_00F0);
      chk("out_data", {24'h0, out_a}, 32'hF0);
      bus_wr(0, ADDR_OUTSET, 32'h0000_0003);
      chk("out_set", {24'h0, out_a}, 32'hF3);
      bus_wr(0, ADDR_OUTCLR, 32'h0000_0030);
      chk("out_clr", {24'h0, out_a}, 32'hC3);
      bus_rd(0, ADDR_OUTSET, 32'h0, "rd_outset");
      bus_rd(0, ADDR_OUTCLR, 32'h0, "rd_outclr");
      bus_rd(0, ADDR_DATA, 32'h0000_00C3, "rd_data");
      tick(1);
      chk("rd_hold", bus_a.readdata, 32'h0000_00C3);

      // Rising edge on bit2 with its mask already on: irq gives the capture latency.
      bus_wr(0, ADDR_IRQ_MASK, 32'h04);
      in_a = 8'h04;
      tick(1); chk("lat1_irq", {31'h0, irq_a}, 32'h0);
      tick(1); chk("lat2_irq", {31'h0, irq_a}, 32'h0);
      tick(1); chk("lat3_irq", {31'h0, irq_a}, 32'h1);
      bus_rd(0, ADDR_EDGE_CAP, 32'h04, "cap_rise");
      bus_rd(0, ADDR_DATA_IN,  32'h04, "data_in");
      bus_rd(0, ADDR_IRQ_MASK, 32'h04, "rd_mask");
      in_a = 8'h00;
      tick(4);
      bus_rd(0, ADDR_EDGE_CAP, 32'h04, "cap_fall_ignored");
      in_a = 8'h01;
      tick(4);
      bus_rd(0, ADDR_EDGE_CAP, 32'h05, "cap_bit0");
      chk("irq_bit2", {31'h0, irq_a}, 32'h1);
      bus_wr(0, ADDR_EDGE_CAP, 32'h04);
      chk("w1c_irq", {31'h0, irq_a}, 32'h0);
      bus_rd(0, ADDR_EDGE_CAP, 32'h01, "w1c_other_kept");
      bus_wr(0, ADDR_IRQ_MASK, 32'h05);
      chk("mask_on_irq", {31'h0, irq_a}, 32'h1);
      bus_wr(0, ADDR_IRQ_MASK, 32'h04);
      chk("mask_off_irq", {31'h0, irq_a}, 32'h0);

      in_a = 8'h05;
      tick(3);
      chk("rearm_irq", {31'h0, irq_a}, 32'h1);
      in_a = 8'h01;
      tick(4);
      // New rising edge on bit2 reaches the capture register on the same edge as the W1C.
      in_a = 8'h05;
      tick(2);
      bus_wr(0, ADDR_EDGE_CAP, 32'h05);
      chk("coinc_irq", {31'h0, irq_a}, 32'h1);
      bus_rd(0, ADDR_EDGE_CAP, 32'h04, "coinc_cap");
      bus_wr(0, ADDR_EDGE_CAP, 32'h04);
      chk("clr_irq", {31'h0, irq_a}, 32'h0);

      bus_wr(0, 3'd6, 32'hFFFF_FFFF);
      bus_wr(0, ADDR_DATA_IN, 32'hFFFF_FFFF);
      chk("off6_out", {24'h0, out_a}, 32'hC3);
      bus_rd(0, 3'd6, 32'h0, "rd_off6");
      bus_rd(0, 3'd7, 32'h0, "rd_off7");
      bus_rd(0, ADDR_IRQ_MASK, 32'h04, "off6_mask");
      bus_wr(0, ADDR_DATA, 32'hABCD_0012);
      bus_rd(0, ADDR_DATA, 32'h0000_0012, "upper_zero");

      // 32-bit bank, any-edge capture, three-stage synchroniser.
      bus_wr(1, ADDR_IRQ_MASK, 32'h8000_0000);
      in_b = 32'h8000_0000;
      tick(3); chk("b_lat3_irq", {31'h0, irq_b}, 32'h0);
      tick(1); chk("b_lat4_irq", {31'h0, irq_b}, 32'h1);
      bus_rd(1, ADDR_EDGE_CAP, 32'h8000_0000, "b_cap1");
      bus_wr(1, ADDR_EDGE_CAP, 32'h8000_0000);
      chk("b_w1c_irq", {31'h0, irq_b}, 32'h0);
      bus_rd(1, ADDR_EDGE_CAP, 32'h0, "b_cap_clr");
      in_b = 32'h0;
      tick(5);
      bus_rd(1, ADDR_EDGE_CAP, 32'h8000_0000, "b_cap2");
      bus_wr(1, ADDR_OUTSET, 32'h8000_0000);
      chk("b_outset", out_b, RV_B | 32'h8000_0000);
      bus_wr(1, ADDR_OUTCLR, 32'h0000_0001);
      chk("b_outclr", out_b, 32'h25A5_0000 | 32'h8000_0000);

      // Pending capture and irq wiped by reset between clock edges.
      bus_wr(0, ADDR_IRQ_MASK, 32'h02);
      in_a = 8'h07;
      tick(3);
      chk("pre_rst_irq", {31'h0, irq_a}, 32'h1);
      bus_wr(0, ADDR_DATA, 32'h3C);
      chk("pre_rst_out", {24'h0, out_a}, 32'h3C);
      reset = 1'b1;
      in_a  = 8'h00;
      #1;
      chk("arst_out_a", {24'h0, out_a}, RV_A);
      chk("arst_irq_a", {31'h0, irq_a}, 32'h0);
      chk("arst_irq_b", {31'h0, irq_b}, 32'h0);
      chk("arst_rd_a",  bus_a.readdata, 32'h0);
      chk("arst_out_b", out_b, RV_B);
      tick(1);
      reset = 1'b0;
      tick(1);
      bus_rd(0, ADDR_EDGE_CAP, 32'h0, "post_rst_cap");
      bus_rd(0, ADDR_IRQ_MASK, 32'h0, "post_rst_mask");
      bus_rd(1, ADDR_EDGE_CAP, 32'h0, "post_rst_cap_b");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/avalon_pio_gpio.md
Name: avalon_pio_gpio

Overview:
- Parametrised successor to the fixed 8-bit output-only PIO: generic GPIO slave on the Avalon-MM bus.
- Configurable-width output register with atomic set/clear.
- Synchronised input port with edge capture and a maskable, level-sensitive interrupt.
- Sits under the Qsys interconnect, one instance per GPIO bank (LEDs, buttons, switches).

Parameters:
- WIDTH, 8, number of GPIO bits in each direction; legal range 1..32.
- RESET_VALUE, 0, value loaded into the output register on reset; only WIDTH LSBs are used.
- SYNC_STAGES, 2, flops in the input synchroniser; legal range 2..4.
- EDGE_TYPE, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data; read latency 1.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register value.
- irq  out  1  level interrupt request, active-high.

Behaviour:
- Reset is asynchronous and active-high: one clock, and reset is applied without waiting for a clock edge.
- Reset values:
  - data_out = RESET_VALUE[WIDTH-1:0]
  - sync chain, prev, edge_capture, irq_mask = 0
  - readdata = 0, so out_port = RESET_VALUE and irq = 0
- Write = chipselect && !write_n. Read = chipselect && write_n.
- Register map, word offsets:
  - 0 DATA (R/W): write loads data_out; read returns data_out.
  - 1 DATA_IN (RO): read returns the synchronised input; writes ignored.
  - 2 IRQ_MASK (R/W).
  - 3 EDGE_CAP (R, W1C): write clears every bit where writedata is 1.
  - 4 OUTSET (WO): data_out |= writedata; reads return 0.
  - 5 OUTCLR (WO): data_out &= ~writedata; reads return 0.
  - 6..7: reads return 0; writes ignored.
- Writes take effect at the clock edge, so out_port changes on the cycle after the write.
- Only writedata[WIDTH-1:0] is used; readdata[31:WIDTH] is always 0.
- Read latency:
  - readdata is registered on every read and holds its last value while not selected.
  - Data appears exactly one cycle after the read cycle.
  - A read and a same-address write cannot coincide; the bus is single-ported.
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in, then one more flop to give prev.
  - Edge detect per bit:
    - rising = sync_in & ~prev
    - falling = ~sync_in & prev
    - any = sync_in ^ prev
  - The input-to-capture latency is SYNC_STAGES + 1 clocks.
- Edge capture:
  - A detected edge sets the corresponding edge_capture bit.
  - The bit stays set until it is cleared by W1C.
  - If an edge and a W1C hit the same bit in the same cycle, set wins and the bit stays 1.
  - Bits not written with 1 are unaffected by W1C.
- Interrupt:
  - irq = |(edge_capture & irq_mask), decoded combinationally from registers.
  - irq asserts the cycle after a capture bit sets with its mask bit at 1.
  - Changing the mask alone affects irq the cycle after the mask write.
- Reset mid-operation forces all state to the reset values immediately; pending captures are lost.

Decomposition:
- Shared package holds:
  - register offset constants: DATA, DATA_IN, IRQ_MASK, EDGE_CAP, OUTSET, OUTCLR
  - EDGE_TYPE encodings: RISING, FALLING, ANY
  - the bus data width constant, 32
- One natural sub-module, pio_sync_edge, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE.
  - Inputs: clk, reset, in_port.
  - Outputs: sync_in, edge_pulse.
- The top level holds the register file, the address decode and the readdata register.

Test Plan:
- Reset with RESET_VALUE=0x5A, WIDTH=8 -> out_port=0x5A, irq=0, readdata=0; a read of offset 0 returns 0x0000005A one cycle later.
- Write 0xF0 to DATA, then 0x03 to OUTSET, then 0x30 to OUTCLR -> out_port goes 0xF0, 0xF3, 0xC3, each one cycle after its write; a read of OUTSET returns 0.
- EDGE_TYPE=0, SYNC_STAGES=2, in_port bit2 driven 0->1 -> EDGE_CAP reads 0x04; the bit sets 3 clocks after the input change.
- Then driving bit2 1->0 -> EDGE_CAP is unchanged at 0x04.
- IRQ_MASK=0x04 with EDGE_CAP bit2 set -> irq=1.
  - Write 0x04 to EDGE_CAP -> irq=0 next cycle.
  - A W1C on bit2 coincident with a new rising edge on bit2 -> bit stays 1 and irq stays 1.
- WIDTH=32, EDGE_TYPE=2, toggle in_port bit31 twice -> capture bit31 is set after the first toggle; a W1C of 0x80000000 clears it; the second toggle sets it again.
- Write to offset 6, read offsets 6/7 -> no state change and readdata=0.
- Assert reset mid-burst with pending captures -> EDGE_CAP=0, irq=0 and out_port=RESET_VALUE immediately, without waiting for a clock edge.
